// File: rtl/prog_loader.sv
// -----------------------------------------------------------------------------
// prog_loader
//
// Purpose:
//   Write-side loader for the program RAM. It accepts a byte stream over a
//   valid/ready handshake and writes it to consecutive addresses starting at
//   address 0, using a registered write port. When the stream ends, it appends
//   a 0x00 terminator so the CPU fetch logic can find the end of the program.
//   It reports completion, program length and truncation to the top level.
//   The top level holds the CPU in reset while busy is high.
//
// Parameters:
//   DATA_WIDTH  memory word width (>= 8); bytes are zero-extended into wdata
//   ADDR_WIDTH  program memory address width
//   NUM_WORDS   memory depth (2 .. 2**ADDR_WIDTH); the last slot always holds
//               the terminator, so at most NUM_WORDS-1 program bytes are kept
//
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   asynchronous active-high reset
//   start     in   one-cycle pulse, begins a load from IDLE or DONE
//   in_valid  in   input byte valid
//   in_data   in   input byte
//   in_ready  out  loader accepts in_data this cycle (high only while loading)
//   wen       out  registered memory write enable, one-cycle pulse per write
//   waddr     out  registered memory write address (holds when wen=0)
//   wdata     out  registered memory write data (holds when wen=0)
//   busy      out  load in progress
//   done      out  load complete
//   overflow  out  sticky: program was truncated at capacity
//   length    out  stored program bytes excluding terminator (valid with done)
//
// Build option:
//   PROG_LOADER_FILTER_EN  when defined, only the eight command bytes
//                          + - < > [ ] . , are stored. Other nonzero bytes are
//                          consumed but dropped. 0x00 always terminates.
// -----------------------------------------------------------------------------
module prog_loader #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int NUM_WORDS  = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  wen,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic [ADDR_WIDTH:0]   length
);

    // One extra bit so a full count (up to NUM_WORDS-1) and length share a width.
    localparam int CW = ADDR_WIDTH + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_TERM,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         count_q, count_d;
    logic [CW-1:0]         length_q, length_d;
    logic                  overflow_q, overflow_d;
    logic                  done_q, done_d;
    logic                  wen_q, wen_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

    logic [CW-1:0]         count_inc;
    logic                  byte_kept;

`ifdef PROG_LOADER_FILTER_EN
    always_comb begin
        unique case (in_data)
            8'h2B, 8'h2D, 8'h3C, 8'h3E,
            8'h5B, 8'h5D, 8'h2E, 8'h2C: byte_kept = 1'b1;
            default:                    byte_kept = 1'b0;
        endcase
    end
`else
    assign byte_kept = 1'b1;
`endif

    assign count_inc = count_q + CW'(1);

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can
        // leave one unassigned and infer a latch.
        state_d    = state_q;
        count_d    = count_q;
        length_d   = length_q;
        overflow_d = overflow_q;
        done_d     = 1'b0;
        wen_d      = 1'b0;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        in_ready   = 1'b0;
        busy       = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                    count_d = '0;
                end
            end

            S_LOAD: begin
                // Ready depends only on state, so a source may wait for ready.
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid) begin
                    if (in_data == 8'h00) begin
                        state_d = S_TERM;
                    end else if (byte_kept) begin
                        wen_d   = 1'b1;
                        waddr_d = count_q[ADDR_WIDTH-1:0];
                        wdata_d = DATA_WIDTH'(in_data);
                        count_d = count_inc;
                        // Stop one slot early: the last word is reserved for
                        // the terminator.
                        if (count_inc == CW'(NUM_WORDS - 1)) begin
                            overflow_d = 1'b1;
                            state_d    = S_TERM;
                        end
                    end
                end
            end

            S_TERM: begin
                busy     = 1'b1;
                wen_d    = 1'b1;
                waddr_d  = count_q[ADDR_WIDTH-1:0];
                wdata_d  = '0;
                length_d = count_q;
                state_d  = S_DONE;
            end

            S_DONE: begin
                // done is registered, so it rises the cycle after the
                // terminator write lands and drops as soon as start is seen.
                done_d = !start;
                if (start) begin
                    state_d    = S_LOAD;
                    count_d    = '0;
                    length_d   = '0;
                    overflow_d = 1'b0;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            length_q   <= '0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
            wen_q      <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            length_q   <= length_d;
            overflow_q <= overflow_d;
            done_q     <= done_d;
            wen_q      <= wen_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
        end
    end

    assign wen      = wen_q;
    assign waddr    = waddr_q;
    assign wdata    = wdata_q;
    assign done     = done_q;
    assign overflow = overflow_q;
    assign length   = length_q;

endmodule
